// File: rtl/microsequencer.sv
// Next-state generator for the multicycle MIPS control unit: produces the registered
// microstore address, with one-level call/return and a bounded MOC wait.
module microsequencer #(
  parameter int STATE_W     = 7,
  parameter int NUM_STATES  = 37,
  parameter int RESET_STATE = 0,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         N,
  input  logic [1:0]         S,
  input  logic               Inv,
  input  logic [STATE_W-1:0] CR,
  input  logic [STATE_W-1:0] decodedState,
  input  logic               MOC,
  input  logic               cond,
  output logic [STATE_W-1:0] currentState,
  output logic [STATE_W-1:0] retState,
  output logic               busError,
  output logic [7:0]         waitCount
);

  localparam logic [STATE_W-1:0] RESET_ADDR = STATE_W'(RESET_STATE);
  localparam logic [STATE_W:0]   STATE_LIM  = (STATE_W+1)'(NUM_STATES);
  localparam logic [7:0]         WAIT_LAST  = 8'(MOC_TIMEOUT - 1);

  localparam logic [2:0] N_DECODE = 3'b000;
  localparam logic [2:0] N_RESET  = 3'b001;
  localparam logic [2:0] N_JUMP   = 3'b010;
  localparam logic [2:0] N_INC    = 3'b011;
  localparam logic [2:0] N_BRANCH = 3'b100;
  localparam logic [2:0] N_WAIT   = 3'b101;
  localparam logic [2:0] N_CALL   = 3'b110;
  localparam logic [2:0] N_RET    = 3'b111;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] ret_q, ret_d;
  logic               err_q, err_d;
  logic [7:0]         wait_q, wait_d;

  logic               sel_cond;
  logic               c;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] next_raw;
  logic               wait_cycle;
  logic               timeout;
  logic               illegal;

  always_comb begin
    sel_cond = 1'b0;
    case (S)
      2'b00:   sel_cond = MOC;
      2'b01:   sel_cond = cond;
      2'b10:   sel_cond = 1'b1;
      default: sel_cond = 1'b0;
    endcase
    c   = sel_cond ^ Inv;
    inc = state_q + 1'b1;
  end

  always_comb begin
    next_raw = RESET_ADDR;
    case (N)
      N_DECODE: next_raw = decodedState;
      N_RESET:  next_raw = RESET_ADDR;
      N_JUMP:   next_raw = CR;
      N_INC:    next_raw = inc;
      N_BRANCH: next_raw = c ? CR : inc;
      N_WAIT:   next_raw = c ? CR : state_q;
      N_CALL:   next_raw = CR;
      N_RET:    next_raw = ret_q;
      default:  next_raw = RESET_ADDR;
    endcase
  end

  // A rising condition on the final wait cycle wins over the timeout.
  always_comb begin
    wait_cycle = (N == N_WAIT) && !c;
    timeout    = wait_cycle && (wait_q == WAIT_LAST);
    illegal    = ({1'b0, next_raw} >= STATE_LIM);
  end

  always_comb begin
    state_d = next_raw;
    ret_d   = ret_q;
    err_d   = err_q;
    wait_d  = 8'd0;

    if (timeout) begin
      state_d = RESET_ADDR;
      err_d   = 1'b1;
      wait_d  = 8'd0;
    end else begin
      if (illegal) begin
        state_d = RESET_ADDR;
      end
      if (wait_cycle) begin
        wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      end
    end

    // retState stores the raw increment; a later return re-checks legality.
    if (N == N_CALL) begin
      ret_d = inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_ADDR;
      ret_q   <= '0;
      err_q   <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign currentState = state_q;
  assign retState     = ret_q;
  assign busError     = err_q;
  assign waitCount    = wait_q;

endmodule
